// File: rtl/unified_mem_arbiter.sv
// Arbiter sequencing one single-ported memory between the fetch and data ports, with stall generation.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; the default gives data fixed priority.
module unified_mem_arbiter #(
    parameter int LATENCY = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_write,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_f,
    output logic              stall_m
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [3:0] LAST_CNT = 4'(LATENCY - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              owner_dm_q, owner_dm_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              grant_dm;
    logic              last_cycle;

    assign last_cycle = (cnt_q == LAST_CNT);

`ifdef MEM_ARB_RR_EN
    // On a tie the requester not served last wins; the pointer starts at IF so data wins first.
    logic last_dm_q, last_dm_d;

    always_comb begin
        grant_dm  = dm_req & (~if_req | ~last_dm_q);
        last_dm_d = last_dm_q;
        if (state_q == IDLE && (if_req || dm_req)) begin
            last_dm_d = grant_dm;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_dm_q <= 1'b0;
        end else begin
            last_dm_q <= last_dm_d;
        end
    end
`else
    assign grant_dm = dm_req;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_dm_d = owner_dm_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        case (state_q)
            IDLE: begin
                if (if_req || dm_req) begin
                    owner_dm_d = grant_dm;
                    we_d       = grant_dm & dm_write;
                    addr_d     = grant_dm ? dm_addr : if_addr;
                    wdata_d    = dm_wdata;
                    cnt_d      = 4'd0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 4'd1;
                if (last_cycle) begin
                    state_d = RESP;
                    if (!we_q) begin
                        if (owner_dm_q) begin
                            dm_rdata_d = mem_rdata;
                        end else begin
                            if_rdata_d = mem_rdata;
                        end
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            owner_dm_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_dm_q <= owner_dm_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    // Gating with rst keeps an interrupted write from ever reaching the memory.
    assign mem_en    = (state_q == BUSY) & ~rst;
    assign mem_we    = mem_en & we_q & last_cycle;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_ready  = (state_q == RESP) & ~owner_dm_q;
    assign dm_ready  = (state_q == RESP) & owner_dm_q;
    assign stall_f   = if_req & ~if_ready;
    assign stall_m   = dm_req & ~dm_ready;

endmodule
